// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM slave: FSM encoding and command codes.
package spi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Two-bit command prefix carried in rx_data[DATA_W+1:DATA_W].
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Serial/parallel datapath for the SPI slave: MOSI frame assembly and MISO
// read-data serialisation. Sequencing is decided by the FSM in the top.
module spi_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_start,   // first (command MSB) bit of a frame
    input  logic              rx_en,      // shift one further frame bit
    input  logic              rx_last,    // this shift completes the frame
    input  logic              mosi,
    input  logic              tx_load,    // capture read data and emit its MSB
    input  logic              tx_abort,   // slave deselected: silence MISO
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W+1:0] rx_data,
    output logic              miso
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // Holds every frame bit except the one arriving on the completing cycle.
    logic [DATA_W:0]      rx_sr;
    logic [DATA_W-1:0]    tx_sr;
    logic [CNT_W-1:0]     tx_cnt;

    // Frame assembly; rx_data only updates when a whole frame has arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr   <= '0;
            rx_data <= '0;
        end else if (rx_start) begin
            rx_sr <= {{DATA_W{1'b0}}, mosi};
        end else if (rx_en) begin
            rx_sr <= {rx_sr[DATA_W-1:0], mosi};
            if (rx_last)
                rx_data <= {rx_sr, mosi};
        end
    end

    // Read-data serialiser: MSB appears the cycle after load, then one lower
    // bit per cycle; MISO returns to 0 once the last bit has been shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr  <= '0;
            tx_cnt <= '0;
            miso   <= 1'b0;
        end else if (tx_abort) begin
            tx_sr  <= '0;
            tx_cnt <= '0;
            miso   <= 1'b0;
        end else if (tx_load) begin
            miso   <= tx_data[DATA_W-1];
            tx_sr  <= {tx_data[DATA_W-2:0], 1'b0};
            tx_cnt <= CNT_W'(DATA_W - 1);
        end else if (tx_cnt != '0) begin
            miso   <= tx_sr[DATA_W-1];
            tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
            tx_cnt <= tx_cnt - 1'b1;
        end else begin
            miso <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front-end for a single-port RAM. Receives DATA_W+2 bit frames
// (2-bit command + address/data), strobes them to the RAM, and returns read
// data on MISO after a read-data frame.
module spi_slave_if
    import spi_ram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MOSI,
    input  logic              SS_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             frame_done;    // full frame received, waiting for SS_n rise
    logic             tx_taken;      // read data already latched this frame
    logic             rd_addr_done;  // a read address is pending its data frame

    logic             in_body;
    logic             rx_start, rx_en, rx_last, tx_load;

    assign in_body  = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    assign rx_start = (state == CHK_CMD) && !SS_n;
    assign rx_en    = in_body && !SS_n && !frame_done;
    assign rx_last  = rx_en && (bit_cnt == '0);
    assign tx_load  = (state == READ_DATA) && frame_done && !tx_taken && tx_valid && !SS_n;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: deselect always wins; the body state is chosen by the first
    // bit and whether a read address is outstanding.
    always_comb begin
        state_nxt = state;
        if (SS_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CHK_CMD;
                CHK_CMD: begin
                    if (MOSI == WR_ADDR[1])
                        state_nxt = WRITE;
                    else if (rd_addr_done)
                        state_nxt = READ_DATA;
                    else
                        state_nxt = READ_ADD;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Frame bookkeeping: bit counter, completion, one-shot strobe, read flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            frame_done   <= 1'b0;
            tx_taken     <= 1'b0;
            rx_valid     <= 1'b0;
            rd_addr_done <= 1'b0;
        end else begin
            rx_valid <= rx_last;
            if (SS_n) begin
                bit_cnt    <= '0;
                frame_done <= 1'b0;
                tx_taken   <= 1'b0;
            end else if (rx_start) begin
                bit_cnt    <= CNT_W'(DATA_W);
                frame_done <= 1'b0;
                tx_taken   <= 1'b0;
            end else begin
                if (rx_en && bit_cnt != '0)
                    bit_cnt <= bit_cnt - 1'b1;
                if (rx_last)
                    frame_done <= 1'b1;
                if (tx_load)
                    tx_taken <= 1'b1;
            end
            if (rx_last && state == READ_ADD)
                rd_addr_done <= 1'b1;
            else if (rx_last && state == READ_DATA)
                rd_addr_done <= 1'b0;
        end
    end

    spi_shift_reg #(.DATA_W(DATA_W)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_start (rx_start),
        .rx_en    (rx_en),
        .rx_last  (rx_last),
        .mosi     (MOSI),
        .tx_load  (tx_load),
        .tx_abort (SS_n),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .miso     (MISO)
    );

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: table of full frames plus hand-written
// read, abort, reset and spurious tx_valid sequences.
module tb_spi_slave_if;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       MOSI;
    logic       SS_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int miso_hi = 0;

    spi_slave_if #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MOSI     (MOSI),
        .SS_n     (SS_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) pulses++;
        if (MISO) miso_hi++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    typedef struct {
        string      name;
        logic [9:0] frame;
        logic [9:0] exp_rx;
        logic       exp_flag;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Assert SS_n and send the top n bits of f, MSB first. Returns just after
    // the clock edge that sampled the last bit.
    task automatic send_bits(input logic [9:0] f, input int n);
        @(negedge clk) SS_n = 1'b0;
        @(posedge clk);
        for (int i = 9; i > 9 - n; i--) begin
            @(negedge clk) MOSI = f[i];
            @(posedge clk);
        end
    endtask

    task automatic end_frame(input string name);
        @(negedge clk) begin SS_n = 1'b1; MOSI = 1'b0; end
        @(posedge clk) #1;
        chk({name, "_idle"}, 32'(dut.state), 32'(IDLE));
    endtask

    // Full frame, strobe check, then extra cycles with SS_n low that must not
    // disturb the captured frame.
    task automatic run_frame(input string name, input logic [9:0] f,
                             input logic [9:0] exp_rx, input logic exp_flag);
        int p0, m0;
        p0 = pulses;
        m0 = miso_hi;
        send_bits(f, 10);
        #1;
        chk({name, "_rx_valid"}, 32'(rx_valid), 32'd1);
        chk({name, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
        chk({name, "_flag"}, 32'(dut.rd_addr_done), 32'(exp_flag));
        repeat (3) @(negedge clk) MOSI = ~MOSI;
        #1;
        chk({name, "_pulses"}, 32'(pulses - p0), 32'd1);
        chk({name, "_hold"}, 32'(rx_data), 32'(exp_rx));
        chk({name, "_miso"}, 32'(miso_hi - m0), 32'd0);
    endtask

    logic [7:0] exp_miso;
    int p0, m0;

    initial begin
        vecs[0] = '{"wr_addr",   10'b00_00000110, 10'b00_00000110, 1'b0};
        vecs[1] = '{"wr_data",   10'b01_10100101, 10'b01_10100101, 1'b0};
        vecs[2] = '{"rd_addr",   10'b10_00000110, 10'b10_00000110, 1'b1};
        vecs[3] = '{"wr_keep",   10'b00_11111111, 10'b00_11111111, 1'b1};
        vecs[4] = '{"rd_data",   10'b11_01010101, 10'b11_01010101, 1'b0};
        vecs[5] = '{"rd_addr2",  10'b10_10000001, 10'b10_10000001, 1'b1};
        vecs[6] = '{"rd_data2",  10'b11_00000000, 10'b11_00000000, 1'b0};

        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        #12;
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_flag", 32'(dut.rd_addr_done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].name, vecs[v].frame, vecs[v].exp_rx, vecs[v].exp_flag);
            end_frame(vecs[v].name);
        end

        // Read sequence: address frame, deselect, data frame, then C3 on MISO.
        exp_miso = 8'hC3;
        run_frame("seq_rd_addr", 10'b10_00000110, 10'b10_00000110, 1'b1);
        end_frame("seq_rd_addr");
        run_frame("seq_rd_data", 10'b11_00000000, 10'b11_00000000, 1'b0);
        @(negedge clk) begin tx_valid = 1'b1; tx_data = 8'hC3; end
        @(negedge clk) begin tx_valid = 1'b0; tx_data = 8'h00; end
        chk("miso_bit7", 32'(MISO), 32'(exp_miso[7]));
        for (int k = 6; k >= 0; k--) begin
            @(negedge clk);
            chk($sformatf("miso_bit%0d", k), 32'(MISO), 32'(exp_miso[k]));
        end
        @(negedge clk);
        chk("miso_after", 32'(MISO), 32'd0);
        m0 = miso_hi;
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk) tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("miso_relatch", 32'(miso_hi - m0), 32'd0);
        end_frame("seq_rd_data");

        // Abort after 5 bits of a read-address frame.
        p0 = pulses;
        send_bits(10'b10_11001100, 5);
        end_frame("abort");
        repeat (3) @(negedge clk);
        chk("abort_pulses", 32'(pulses - p0), 32'd0);
        chk("abort_flag", 32'(dut.rd_addr_done), 32'd0);
        run_frame("post_abort", 10'b01_00111100, 10'b01_00111100, 1'b0);
        end_frame("post_abort");

        // Reset during READ_DATA serialisation.
        run_frame("rst_rd_addr", 10'b10_00000001, 10'b10_00000001, 1'b1);
        end_frame("rst_rd_addr");
        run_frame("rst_rd_data", 10'b11_00000001, 10'b11_00000001, 1'b0);
        @(negedge clk) begin tx_valid = 1'b1; tx_data = 8'hC3; end
        @(negedge clk) begin tx_valid = 1'b0; end
        chk("rst_mid_active", 32'(MISO), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_miso", 32'(MISO), 32'd0);
        chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_mid_flag", 32'(dut.rd_addr_done), 32'd0);
        chk("rst_mid_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk) begin rst_n = 1'b1; SS_n = 1'b1; end
        @(negedge clk);
        send_bits(10'b10_00000000, 1);
        #1;
        chk("post_rst_state", 32'(dut.state), 32'(READ_ADD));
        end_frame("post_rst_partial");
        chk("partial_flag", 32'(dut.rd_addr_done), 32'd0);
        run_frame("post_rst_frame", 10'b10_01110111, 10'b10_01110111, 1'b1);
        end_frame("post_rst_frame");

        // Spurious tx_valid in IDLE and during a WRITE frame.
        m0 = miso_hi;
        tx_valid = 1'b1; tx_data = 8'hFF;
        repeat (3) @(negedge clk);
        run_frame("spur_wr", 10'b00_10101010, 10'b00_10101010, 1'b1);
        end_frame("spur_wr");
        repeat (2) @(negedge clk);
        tx_valid = 1'b0;
        chk("spur_miso", 32'(miso_hi - m0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
